// File: rtl/cycle_term_ctl_if.sv
// ---------------------------------------------------------------------------
// cycle_term_ctl_if
// Bus-side signal bundle between the 68030 CPU strobes / address decoder and
// the cycle-termination controller.
//   master : CPU/decoder side  - drives nAS, nDS, RnW, nSEL
//                                observes DSACK, BERR, BUSY, CH_ACTIVE
//   slave  : controller side   - the reverse
// Parameter NUM_CH sets the chip-select width.
// ---------------------------------------------------------------------------
interface cycle_term_ctl_if #(
  parameter int NUM_CH = 4
);
  logic              nAS;
  logic              nDS;
  logic              RnW;
  logic [NUM_CH-1:0] nSEL;
  logic [1:0]        DSACK;
  logic              BERR;
  logic              BUSY;
  logic [2:0]        CH_ACTIVE;

  modport master (
    output nAS, nDS, RnW, nSEL,
    input  DSACK, BERR, BUSY, CH_ACTIVE
  );

  modport slave (
    input  nAS, nDS, RnW, nSEL,
    output DSACK, BERR, BUSY, CH_ACTIVE
  );
endinterface

// File: rtl/cycle_term_ctl.sv
// ---------------------------------------------------------------------------
// cycle_term_ctl
// Bus-cycle termination controller for the 68030 board. Latches the single
// active-low chip select seen with nAS low, waits a per-channel number of
// DRAM_CLKs, then returns that channel's DSACK port-size code gated by nDS.
// Read-only channels are not acknowledged on writes. Optional bus-error
// timer (macro BUS_TIMEOUT_EN) raises BERR on cycles nobody terminates.
//
// Ports
//   DRAM_CLK  in   system clock (2x CPU_CLK)
//   nRST      in   asynchronous active-low reset
//   bus       slave modport of cycle_term_ctl_if:
//               nAS, nDS, RnW, nSEL[NUM_CH]   CPU strobes and chip selects
//               DSACK[1:0], BERR              termination (active-high)
//               BUSY, CH_ACTIVE[2:0]          status, registered
//
// Configuration macro: BUS_TIMEOUT_EN (undefined -> BERR tied low).
// ---------------------------------------------------------------------------
module cycle_term_ctl #(
  parameter int                      NUM_CH     = 4,
  parameter int                      WAIT_W     = 4,
  parameter logic [NUM_CH*WAIT_W-1:0] CH_WAITS  = {NUM_CH{4'd2}},
  parameter logic [NUM_CH*2-1:0]     CH_PORT    = {NUM_CH{2'b10}},
  parameter logic [NUM_CH-1:0]       CH_RDONLY  = {NUM_CH{1'b0}},
  parameter int                      TMO_W      = 7,
  parameter int                      TMO_CYCLES = 127
) (
  input logic           DRAM_CLK,
  input logic           nRST,
  cycle_term_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [1:0]        dsack_q;
  logic [2:0]        ch_q;
  logic              busy_q;

  // Select decode: exactly one low bit makes a valid channel.
  logic [3:0]        low_cnt_d;
  logic [2:0]        sel_ch_d;
  logic              sel_valid_d;
  logic [WAIT_W-1:0] sel_wait_d;
  logic              sel_ro_d;
  logic [1:0]        ch_port_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    low_cnt_d = '0;
    sel_ch_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bus.nSEL[i]) begin
        low_cnt_d = low_cnt_d + 4'd1;
        sel_ch_d  = 3'(i);
      end
    end
    sel_valid_d = (low_cnt_d == 4'd1);
    sel_wait_d  = CH_WAITS[int'(sel_ch_d)*WAIT_W +: WAIT_W];
    sel_ro_d    = CH_RDONLY[int'(sel_ch_d)];
    ch_port_d   = CH_PORT[int'(ch_q)*2 +: 2];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dsack_q <= 2'b00;
      ch_q    <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.nAS && sel_valid_d) begin
            ch_q   <= sel_ch_d;
            busy_q <= 1'b1;
            if (!bus.RnW && sel_ro_d) begin
              // Write to a read-only channel: park in DONE without DSACK.
              dsack_q <= 2'b00;
              state_q <= DONE;
            end else begin
              cnt_q   <= sel_wait_d;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.nAS) begin
            // CPU abandoned the cycle; no acknowledge is issued.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ch_q    <= 3'd0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            dsack_q <= ch_port_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.nAS) begin
            state_q <= IDLE;
            dsack_q <= 2'b00;
            busy_q  <= 1'b0;
            ch_q    <= 3'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          dsack_q <= 2'b00;
          busy_q  <= 1'b0;
          ch_q    <= 3'd0;
        end
      endcase
    end
  end

  // DSACK falls combinationally with nDS so the CPU sees termination end
  // without waiting for a DRAM_CLK edge.
  assign bus.DSACK     = dsack_q & {2{~bus.nDS}};
  assign bus.BUSY      = busy_q;
  assign bus.CH_ACTIVE = ch_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYCLES);

  logic [TMO_W-1:0] tmo_q;

  // Runs off nAS alone so any unterminated cycle errors, whatever the FSM did.
  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_q <= '0;
    end else if (bus.nAS) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign bus.BERR = (tmo_q == TMO_MAX);
`else
  assign bus.BERR = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_term_ctl.sv
// ---------------------------------------------------------------------------
// tb_cycle_term_ctl
// Directed-plus-random bench for cycle_term_ctl. Channel table:
//   ch0: W=5, 8-bit,  read-only
//   ch1: W=2, 16-bit
//   ch2: W=0, 32-bit
//   ch3: W=8, 16-bit
// Expected outputs come from a per-cycle arithmetic model: k edges after the
// select edge, DSACK is the port code once k >= W+1 (gated by nDS), BUSY and
// CH_ACTIVE reflect a valid select, BERR once nAS has been low TMO clocks.
// ---------------------------------------------------------------------------
module tb_cycle_term_ctl;

  localparam int NUM_CH = 4;
  localparam int TMO    = 127;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  int         w_tab [NUM_CH] = '{5, 2, 0, 8};
  logic [1:0] p_tab [NUM_CH] = '{2'b01, 2'b10, 2'b11, 2'b10};
  bit         ro_tab[NUM_CH] = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic clk;
  logic nRST;
  int   n_tests = 0;
  int   n_fail  = 0;

  cycle_term_ctl_if #(.NUM_CH(NUM_CH)) bus ();

  cycle_term_ctl #(
    .NUM_CH    (NUM_CH),
    .WAIT_W    (4),
    .CH_WAITS  ({4'd8, 4'd0, 4'd2, 4'd5}),
    .CH_PORT   ({2'b10, 2'b11, 2'b10, 2'b01}),
    .CH_RDONLY (4'b0001),
    .TMO_W     (7),
    .TMO_CYCLES(TMO)
  ) dut (
    .DRAM_CLK(clk),
    .nRST    (nRST),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " dsack"}, 8'(bus.DSACK), 8'h0);
    check({tag, " busy"},  8'(bus.BUSY), 8'h0);
    check({tag, " ch"},    8'(bus.CH_ACTIVE), 8'h0);
    check({tag, " berr"},  8'(bus.BERR), 8'h0);
  endtask

  // One bus cycle: nAS low for len edges, then one edge with nAS high.
  // rst_at >= 0 pulls nRST low just after edge rst_at and ends the cycle there.
  task automatic run_cycle(input string tag, input logic [3:0] sel, input logic rnw,
                           input int len, input int rst_at);
    int         n_low;
    int         ch;
    bit         valid;
    bit         acked;
    logic [1:0] exp_q;
    n_low = 0;
    ch    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!sel[i]) begin
        n_low++;
        ch = i;
      end
    end
    valid = (n_low == 1);
    acked = valid && !(rnw == 1'b0 && ro_tab[ch]);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      bus.nAS  = 1'b0;
      bus.RnW  = rnw;
      bus.nSEL = (k == 0 || !valid) ? sel : 4'($urandom);
      bus.nDS  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      exp_q = (acked && k >= w_tab[ch] + 1) ? p_tab[ch] : 2'b00;
      check({tag, " dsack"}, 8'(bus.DSACK), 8'(exp_q & {2{~bus.nDS}}));
      check({tag, " busy"},  8'(bus.BUSY), 8'(valid));
      check({tag, " ch"},    8'(bus.CH_ACTIVE), valid ? 8'(ch) : 8'h0);
      check({tag, " berr"},  8'(bus.BERR), 8'(TMO_ON && (k + 1 >= TMO)));
      if (k == rst_at) begin
        #2 nRST = 1'b0;
        #1 check_idle({tag, " async rst"});
        @(negedge clk);
        bus.nAS  = 1'b1;
        bus.nDS  = 1'b1;
        bus.nSEL = '1;
        nRST     = 1'b1;
        return;
      end
    end
    @(negedge clk);
    bus.nAS  = 1'b1;
    bus.nDS  = 1'b1;
    bus.nSEL = '1;
    @(posedge clk);
    #1;
    check_idle({tag, " end"});
  endtask

  initial begin
    logic [3:0] sel;
    int         ch;
    int         len;
    nRST     = 1'b0;
    bus.nAS  = 1'b1;
    bus.nDS  = 1'b1;
    bus.RnW  = 1'b1;
    bus.nSEL = '1;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;

    // Read ch1, W=2: DSACK=10 from edge 3 when nDS low.
    run_cycle("rd ch1", 4'b1101, 1'b1, 6, -1);
    // W=0, 32-bit port, back-to-back with one nAS-high edge between.
    run_cycle("w0 a", 4'b1011, 1'b1, 3, -1);
    run_cycle("w0 b", 4'b1011, 1'b1, 3, -1);
    // Two selects low: nothing acknowledges; only the timer may end it.
    run_cycle("dual sel", 4'b1100, 1'b1, TMO + 3, -1);
    // Write to read-only ch0.
    run_cycle("ro wr", 4'b1110, 1'b0, TMO + 3, -1);
    // Read of ch0 is still acknowledged.
    run_cycle("ro rd", 4'b1110, 1'b1, 8, -1);
    // ch3 W=8 aborted after 3 clocks, then a normal ch3 cycle.
    run_cycle("abort", 4'b0111, 1'b1, 3, -1);
    run_cycle("after abort", 4'b0111, 1'b0, 12, -1);
    // Reset while DONE is holding DSACK on ch1.
    run_cycle("rst done", 4'b1101, 1'b1, 8, 4);
    run_cycle("post rst", 4'b1101, 1'b0, 5, -1);

    for (int n = 0; n < 25; n++) begin
      ch  = $urandom_range(0, NUM_CH - 1);
      sel = 4'b1111;
      sel[ch] = 1'b0;
      if ($urandom_range(0, 4) == 0) sel = 4'($urandom);
      len = $urandom_range(1, 13);
      run_cycle("rand", sel, 1'($urandom_range(0, 1)), len, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
